// File: rtl/cov_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cov_pkg
// Description : Shared types, default widths and the saturating round/shift
//               helper used by the covariance systolic array processing
//               elements.
// Revision    : 1.0 - initial release
// ============================================================================
package cov_pkg;

   // Default widths for the covariance array
   localparam int C_DATA_WIDTH  = 16;
   localparam int C_ACC_WIDTH   = 40;
   localparam int C_OUT_WIDTH   = 32;
   localparam int C_SHIFT_BITS  = 5;

   // Working width of the round/shift/saturate helper; ACC_WIDTH must stay
   // well below this so the rounding addend can never overflow it.
   localparam int C_SAT_WIDTH   = 64;

   // Complex sample at the default data width (q = real, i = imaginary)
   typedef struct packed {
      logic signed [C_DATA_WIDTH-1:0] q;
      logic signed [C_DATA_WIDTH-1:0] i;
   } cplx_t;

   // Result of sat_rshift: the clipped value and a clip flag
   typedef struct packed {
      logic signed [C_SAT_WIDTH-1:0] value;
      logic                          ovf;
   } sat_t;

   // Round-half-up, arithmetic right shift, then clip to a signed out_w range.
   function automatic sat_t sat_rshift(input logic signed [C_SAT_WIDTH-1:0] value,
                                       input int unsigned                   shift,
                                       input int unsigned                   out_w);
      logic signed [C_SAT_WIDTH-1:0] rnd;
      logic signed [C_SAT_WIDTH-1:0] shv;
      logic signed [C_SAT_WIDTH-1:0] hi;
      logic signed [C_SAT_WIDTH-1:0] lo;
      sat_t                          res;
      rnd = value;
      if (shift != 0) begin
         rnd = value + (64'sd1 <<< (shift - 32'd1));
      end
      shv = rnd >>> shift;
      hi  = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
      lo  = -(64'sd1 <<< (out_w - 32'd1));
      res.ovf = 1'b0;
      if (shv > hi) begin
         res.value = hi;
         res.ovf   = 1'b1;
      end else if (shv < lo) begin
         res.value = lo;
         res.ovf   = 1'b1;
      end else begin
         res.value = shv;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmul_conj.sv
`default_nettype none
// ============================================================================
// Module      : cmul_conj
// Description : Registered complex product a*conj(b) (stage 1 of the PE).
//               Products are sign-extended to the accumulator width and
//               registered together with the valid/last/shift tags. A
//               diagonal instance builds only the two real-part multipliers.
// Revision    : 1.0 - initial release
// ============================================================================
module cmul_conj
   import cov_pkg::*;
#(
   parameter int DATA_WIDTH = C_DATA_WIDTH,
   parameter int ACC_WIDTH  = C_ACC_WIDTH,
   parameter int SHIFT_BITS = C_SHIFT_BITS,
   parameter bit DIAG       = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         valid_in,
   input  logic                         last_in,
   input  logic [SHIFT_BITS-1:0]        shift_in,
   input  logic signed [DATA_WIDTH-1:0] a_q,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_q,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic signed [ACC_WIDTH-1:0]  p_q,
   output logic signed [ACC_WIDTH-1:0]  p_i,
   output logic                         valid_s1,
   output logic                         last_s1,
   output logic [SHIFT_BITS-1:0]        shift_s1
);

   // A DATA_WIDTH x DATA_WIDTH signed product always fits in 2*DATA_WIDTH
   // bits; the sum of two of them needs one more.
   localparam int C_PROD_W = 2 * DATA_WIDTH;

   logic signed [C_PROD_W:0]      prod_re_w;
   logic signed [C_PROD_W:0]      prod_im_w;

   logic signed [ACC_WIDTH-1:0]   prod_re_d, prod_re_q;
   logic signed [ACC_WIDTH-1:0]   prod_im_d, prod_im_q;
   logic                          valid_s1_d, valid_s1_q;
   logic                          last_s1_d, last_s1_q;
   logic [SHIFT_BITS-1:0]         shift_s1_d, shift_s1_q;

   if (DIAG) begin : g_diag
      logic signed [C_PROD_W-1:0] m_qq;
      logic signed [C_PROD_W-1:0] m_ii;
      // Real part only; the imaginary product of a diagonal term is zero
      always_comb begin
         m_qq      = C_PROD_W'(a_q) * C_PROD_W'(b_q);
         m_ii      = C_PROD_W'(a_i) * C_PROD_W'(b_i);
         prod_re_w = (C_PROD_W+1)'(m_qq) + (C_PROD_W+1)'(m_ii);
         prod_im_w = '0;
      end
   end else begin : g_full
      logic signed [C_PROD_W-1:0] m_qq;
      logic signed [C_PROD_W-1:0] m_ii;
      logic signed [C_PROD_W-1:0] m_iq;
      logic signed [C_PROD_W-1:0] m_qi;
      // Full a*conj(b): re = aq*bq + ai*bi, im = ai*bq - aq*bi
      always_comb begin
         m_qq      = C_PROD_W'(a_q) * C_PROD_W'(b_q);
         m_ii      = C_PROD_W'(a_i) * C_PROD_W'(b_i);
         m_iq      = C_PROD_W'(a_i) * C_PROD_W'(b_q);
         m_qi      = C_PROD_W'(a_q) * C_PROD_W'(b_i);
         prod_re_w = (C_PROD_W+1)'(m_qq) + (C_PROD_W+1)'(m_ii);
         prod_im_w = (C_PROD_W+1)'(m_iq) - (C_PROD_W+1)'(m_qi);
      end
   end

   // Next stage-1 contents: products and tags, flushed by clr
   always_comb begin
      prod_re_d  = ACC_WIDTH'(prod_re_w);
      prod_im_d  = ACC_WIDTH'(prod_im_w);
      valid_s1_d = valid_in;
      last_s1_d  = valid_in & last_in;
      shift_s1_d = shift_in;
      if (clr) begin
         prod_re_d  = '0;
         prod_im_d  = '0;
         valid_s1_d = 1'b0;
         last_s1_d  = 1'b0;
         shift_s1_d = '0;
      end
   end

   // Stage-1 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_re_q  <= '0;
         prod_im_q  <= '0;
         valid_s1_q <= 1'b0;
         last_s1_q  <= 1'b0;
         shift_s1_q <= '0;
      end else begin
         prod_re_q  <= prod_re_d;
         prod_im_q  <= prod_im_d;
         valid_s1_q <= valid_s1_d;
         last_s1_q  <= last_s1_d;
         shift_s1_q <= shift_s1_d;
      end
   end

   assign p_q      = prod_re_q;
   assign p_i      = prod_im_q;
   assign valid_s1 = valid_s1_q;
   assign last_s1  = last_s1_q;
   assign shift_s1 = shift_s1_q;

endmodule
`default_nettype wire

// File: rtl/pe_cmac_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_cmac_acc
// Description : Complex multiply-accumulate PE for the covariance systolic
//               array. Accumulates a*conj(b) over a frame, then rounds,
//               scales by 2^-shift and saturates the result. Operands hop
//               one register right (a) and down (b) for tiling.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_cmac_acc
   import cov_pkg::*;
#(
   parameter int DATA_WIDTH = C_DATA_WIDTH,
   parameter int ACC_WIDTH  = C_ACC_WIDTH,
   parameter int OUT_WIDTH  = C_OUT_WIDTH,
   parameter int SHIFT_BITS = C_SHIFT_BITS,
   parameter bit DIAG       = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         valid_in,
   input  logic                         last_in,
   input  logic [SHIFT_BITS-1:0]        shift_in,
   input  logic signed [DATA_WIDTH-1:0] a_q,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_q,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic signed [DATA_WIDTH-1:0] a_out_q,
   output logic signed [DATA_WIDTH-1:0] a_out_i,
   output logic signed [DATA_WIDTH-1:0] b_out_q,
   output logic signed [DATA_WIDTH-1:0] b_out_i,
   output logic                         valid_out,
   output logic                         last_out,
   output logic                         res_valid,
   output logic signed [OUT_WIDTH-1:0]  res_q,
   output logic signed [OUT_WIDTH-1:0]  res_i,
   output logic                         ovf
);

   // ---------------------------------------------------------------- stage 1
   logic signed [ACC_WIDTH-1:0]  p_q;
   logic signed [ACC_WIDTH-1:0]  p_i;
   logic                         valid_s1;
   logic                         last_s1;
   logic [SHIFT_BITS-1:0]        shift_s1;

   cmul_conj #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT_BITS (SHIFT_BITS),
      .DIAG       (DIAG)
   ) u_cmul (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .valid_in (valid_in),
      .last_in  (last_in),
      .shift_in (shift_in),
      .a_q      (a_q),
      .a_i      (a_i),
      .b_q      (b_q),
      .b_i      (b_i),
      .p_q      (p_q),
      .p_i      (p_i),
      .valid_s1 (valid_s1),
      .last_s1  (last_s1),
      .shift_s1 (shift_s1)
   );

   // ----------------------------------------------------------- pass-through
   logic signed [DATA_WIDTH-1:0] a_out_q_d, a_out_q_q;
   logic signed [DATA_WIDTH-1:0] a_out_i_d, a_out_i_q;
   logic signed [DATA_WIDTH-1:0] b_out_q_d, b_out_q_q;
   logic signed [DATA_WIDTH-1:0] b_out_i_d, b_out_i_q;
   logic                         valid_out_d, valid_out_q;
   logic                         last_out_d, last_out_q;

   // Neighbour hop: operands and tags move every cycle regardless of valid/clr
   always_comb begin
      a_out_q_d   = a_q;
      a_out_i_d   = a_i;
      b_out_q_d   = b_q;
      b_out_i_d   = b_i;
      valid_out_d = valid_in;
      last_out_d  = last_in;
   end

   // Pass-through register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out_q_q   <= '0;
         a_out_i_q   <= '0;
         b_out_q_q   <= '0;
         b_out_i_q   <= '0;
         valid_out_q <= 1'b0;
         last_out_q  <= 1'b0;
      end else begin
         a_out_q_q   <= a_out_q_d;
         a_out_i_q   <= a_out_i_d;
         b_out_q_q   <= b_out_q_d;
         b_out_i_q   <= b_out_i_d;
         valid_out_q <= valid_out_d;
         last_out_q  <= last_out_d;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic signed [ACC_WIDTH-1:0]  acc_re_d, acc_re_q;
   logic signed [ACC_WIDTH-1:0]  acc_im_d, acc_im_q;
   logic signed [OUT_WIDTH-1:0]  res_re_d, res_re_q;
   logic signed [OUT_WIDTH-1:0]  res_im_d, res_im_q;
   logic                         res_valid_d, res_valid_q;
   logic                         ovf_d, ovf_q;

   logic signed [ACC_WIDTH-1:0]  sum_re;
   logic signed [ACC_WIDTH-1:0]  sum_im;
   sat_t                         sat_re;
   sat_t                         sat_im;

   // Accumulate, or close the frame: round, scale, saturate and restart from 0.
   // clr wins over a closing sample so a flushed frame never reports.
   always_comb begin
      sum_re      = acc_re_q + p_q;
      sum_im      = acc_im_q + p_i;
      sat_re      = sat_rshift(C_SAT_WIDTH'(sum_re), 32'(shift_s1), OUT_WIDTH);
      sat_im      = sat_rshift(C_SAT_WIDTH'(sum_im), 32'(shift_s1), OUT_WIDTH);
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;
      res_valid_d = 1'b0;
      ovf_d       = ovf_q;
      if (clr) begin
         acc_re_d = '0;
         acc_im_d = '0;
         ovf_d    = 1'b0;
      end else if (valid_s1) begin
         if (last_s1) begin
            res_re_d    = sat_re.value[OUT_WIDTH-1:0];
            res_im_d    = DIAG ? '0 : sat_im.value[OUT_WIDTH-1:0];
            ovf_d       = sat_re.ovf | (!DIAG & sat_im.ovf);
            res_valid_d = 1'b1;
            acc_re_d    = '0;
            acc_im_d    = '0;
         end else begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
         end
      end
   end

   // Accumulator and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         res_re_q    <= '0;
         res_im_q    <= '0;
         res_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         res_re_q    <= res_re_d;
         res_im_q    <= res_im_d;
         res_valid_q <= res_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign a_out_q   = a_out_q_q;
   assign a_out_i   = a_out_i_q;
   assign b_out_q   = b_out_q_q;
   assign b_out_i   = b_out_i_q;
   assign valid_out = valid_out_q;
   assign last_out  = last_out_q;
   assign res_valid = res_valid_q;
   assign res_q     = res_re_q;
   assign res_i     = res_im_q;
   assign ovf       = ovf_q;

endmodule
`default_nettype wire
